// File: rtl/lcd1604_bus_receiver_if.sv
// Parallel HD44780-style bus between the LCD1604 controller (master) and the display model (slave).
interface lcd1604_bus_receiver_if;
    logic       rs;
    logic       rw;
    logic       enable;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (output rs, rw, enable, data_in, input  data_out, data_oe);
    modport slave  (input  rs, rw, enable, data_in, output data_out, data_oe);
endinterface

// File: rtl/lcd1604_bus_receiver.sv
// LCD-side responder for the LCD1604 parallel bus: DDRAM image, address counter, display state, busy/status reads.
// Optional display-shift support is enabled with the LCD_RX_SHIFT_EN macro (adds the shift_offset output).
module lcd1604_bus_receiver #(
    parameter int BUSY_CMD    = 37,
    parameter int BUSY_CLEAR  = 1520,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    lcd1604_bus_receiver_if.slave bus,
    output logic                  busy,
    output logic [6:0]            addr_counter,
    output logic                  display_on,
    output logic                  cursor_on,
    output logic                  blink_on,
    output logic                  entry_inc,
    output logic                  two_line,
    input  logic [6:0]            rd_addr,
    output logic [7:0]            rd_char,
    output logic                  cmd_strobe,
    output logic                  overrun
`ifdef LCD_RX_SHIFT_EN
    ,
    output logic [6:0]            shift_offset
`endif
);

    localparam int CNT_W = $clog2(BUSY_CLEAR + BUSY_CMD + 1);

    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

    state_t     state, state_next;
    logic [10:0] sync_q [SYNC_STAGES];
    logic       en_s, rs_s, rw_s, en_prev;
    logic [7:0] data_s;
    logic       fall, is_clear, cnt_zero;
    logic       wr_accept, wr_ignore, clr_done;
    logic [CNT_W-1:0] busy_cnt;
    logic [6:0] clr_addr;
    logic [7:0] ddram [128];

    assign {en_s, rs_s, rw_s, data_s} = sync_q[SYNC_STAGES-1];
    assign fall     = en_prev & ~en_s;
    assign is_clear = ~rs_s && (data_s == 8'h01);
    assign cnt_zero = (busy_cnt == '0);

    // Address counter step including the HD44780 line wrap points.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc, input logic two);
        logic [6:0] r;
        r = inc ? a + 7'd1 : a - 7'd1;
        if (two) begin
            if (inc && a == 7'h27)       r = 7'h40;
            else if (inc && a == 7'h67)  r = 7'h00;
            else if (!inc && a == 7'h40) r = 7'h27;
            else if (!inc && a == 7'h00) r = 7'h67;
        end else begin
            if (inc && a == 7'h4F)       r = 7'h00;
            else if (!inc && a == 7'h00) r = 7'h4F;
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {bus.enable, bus.rs, bus.rw, bus.data_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb begin
        state_next = state;
        wr_accept  = 1'b0;
        wr_ignore  = 1'b0;
        clr_done   = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !rw_s) begin
                    wr_accept  = 1'b1;
                    state_next = is_clear ? CLEAR : EXEC;
                end
            end
            CLEAR: begin
                wr_ignore = fall && !rw_s;
                if (clr_addr == 7'h7F) begin
                    clr_done   = 1'b1;
                    state_next = cnt_zero ? IDLE : EXEC;
                end
            end
            EXEC: begin
                wr_ignore = fall && !rw_s;
                if (cnt_zero) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            busy_cnt     <= '0;
            clr_addr     <= '0;
            en_prev      <= 1'b0;
            addr_counter <= '0;
            display_on   <= 1'b0;
            cursor_on    <= 1'b0;
            blink_on     <= 1'b0;
            entry_inc    <= 1'b1;
            two_line     <= 1'b0;
            cmd_strobe   <= 1'b0;
            overrun      <= 1'b0;
            bus.data_out <= '0;
            bus.data_oe  <= 1'b0;
`ifdef LCD_RX_SHIFT_EN
            shift_offset <= '0;
`endif
        end else begin
            state      <= state_next;
            busy       <= (state_next != IDLE);
            cmd_strobe <= wr_accept;
            en_prev    <= en_s;
            if (wr_ignore) overrun <= 1'b1;

            if (wr_accept)
                busy_cnt <= is_clear ? CNT_W'(BUSY_CLEAR - 1) : CNT_W'(BUSY_CMD - 1);
            else if (state != IDLE && !cnt_zero)
                busy_cnt <= busy_cnt - CNT_W'(1);

            if (wr_accept)          clr_addr <= '0;
            else if (state == CLEAR) clr_addr <= clr_addr + 7'd1;

            if ((fall && rw_s && rs_s) || (wr_accept && rs_s))
                addr_counter <= ac_step(addr_counter, entry_inc, two_line);

            // Instructions are decoded by their highest set bit; clear is handled by the FSM.
            if (wr_accept && !rs_s) begin
                casez (data_s)
                    8'b1???????: addr_counter <= data_s[6:0];
                    8'b01??????: ;
                    8'b001?????: if (data_s[4]) two_line <= data_s[3];
                    8'b0001????: begin
`ifdef LCD_RX_SHIFT_EN
                        if (!data_s[3])
                            addr_counter <= ac_step(addr_counter, data_s[2], two_line);
                        else if (data_s[2])
                            shift_offset <= (shift_offset == 7'd39) ? 7'd0 : shift_offset + 7'd1;
                        else
                            shift_offset <= (shift_offset == 7'd0) ? 7'd39 : shift_offset - 7'd1;
`endif
                    end
                    8'b00001???: begin
                        display_on <= data_s[2];
                        cursor_on  <= data_s[1];
                        blink_on   <= data_s[0];
                    end
                    8'b000001??: entry_inc <= data_s[1];
                    8'b0000001?: begin
                        addr_counter <= '0;
`ifdef LCD_RX_SHIFT_EN
                        shift_offset <= '0;
`endif
                    end
                    default: ;
                endcase
            end

            if (clr_done) begin
                addr_counter <= '0;
                entry_inc    <= 1'b1;
            end

            if (en_s && rw_s) begin
                bus.data_oe  <= 1'b1;
                bus.data_out <= rs_s ? ddram[addr_counter] : {busy, addr_counter};
            end else begin
                bus.data_oe  <= 1'b0;
            end
        end
    end

    // DDRAM is deliberately left unreset; rd_char reads before the same-cycle write lands.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            ddram[clr_addr] <= 8'h20;
        else if (wr_accept && rs_s)
            ddram[addr_counter] <= data_s;
        rd_char <= ddram[rd_addr];
    end

endmodule

// File: tb/tb_lcd1604_bus_receiver.sv
// Directed self-checking bench for lcd1604_bus_receiver (default parameters).
module tb_lcd1604_bus_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy, display_on, cursor_on, blink_on, entry_inc, two_line;
    logic       cmd_strobe, overrun;
    logic [6:0] addr_counter, rd_addr;
    logic [7:0] rd_char;
`ifdef LCD_RX_SHIFT_EN
    logic [6:0] shift_offset;
`endif

    int         checks = 0;
    int         errors = 0;
    bit         strobe;
    int         len;
    logic [7:0] v_hi, v_lo;
    logic       oe_hi, oe_lo;

    lcd1604_bus_receiver_if bus();

    lcd1604_bus_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .addr_counter (addr_counter),
        .display_on   (display_on),
        .cursor_on    (cursor_on),
        .blink_on     (blink_on),
        .entry_inc    (entry_inc),
        .two_line     (two_line),
        .rd_addr      (rd_addr),
        .rd_char      (rd_char),
        .cmd_strobe   (cmd_strobe),
        .overrun      (overrun)
`ifdef LCD_RX_SHIFT_EN
        ,
        .shift_offset (shift_offset)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One enable pulse; reports whether cmd_strobe followed and, if asked, how long busy stayed high.
    task automatic apply_stimulus(input logic rs_v, input logic [7:0] d, input bit measure,
                                  output bit seen, output int blen);
        @(negedge clk);
        bus.rs = rs_v; bus.rw = 1'b0; bus.data_in = d; bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        bus.enable = 1'b0;
        seen = 1'b0;
        blen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (cmd_strobe) seen = 1'b1;
        end
        if (seen && measure) begin
            while (busy && blen < 4000) begin
                blen++;
                @(negedge clk);
            end
        end
    endtask

    task automatic do_write(input logic rs_v, input logic [7:0] d, input int exp_len, input string tag);
        bit s;
        int l;
        apply_stimulus(rs_v, d, 1'b1, s, l);
        check_output({tag, "_strobe"}, 16'(s), 16'd1);
        check_output({tag, "_busy_len"}, 16'(l), 16'(exp_len));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
        check_output({tag, "_idle"}, 16'(busy), 16'd0);
    endtask

    task automatic bus_read(input logic rs_v, output logic [7:0] dh, output logic oh,
                            output logic [7:0] dl, output logic ol);
        @(negedge clk);
        bus.rs = rs_v; bus.rw = 1'b1; bus.enable = 1'b1;
        repeat (4) @(negedge clk);
        dh = bus.data_out; oh = bus.data_oe;
        bus.enable = 1'b0;
        repeat (5) @(negedge clk);
        dl = bus.data_out; ol = bus.data_oe;
        bus.rw = 1'b0;
    endtask

    task automatic peek(input logic [6:0] a, input logic [7:0] exp, input string tag);
        rd_addr = a;
        @(negedge clk);
        check_output(tag, 16'(rd_char), 16'(exp));
    endtask

    initial begin
        reset = 1'b1;
        bus.rs = 1'b0; bus.rw = 1'b0; bus.enable = 1'b0; bus.data_in = 8'h00;
        rd_addr = 7'h00;
        repeat (3) @(negedge clk);
        check_output("rst_data_out", 16'(bus.data_out), 16'h00);
        check_output("rst_data_oe",  16'(bus.data_oe), 16'd0);
        check_output("rst_busy",     16'(busy), 16'd0);
        check_output("rst_ac",       16'(addr_counter), 16'h00);
        check_output("rst_disp",     16'({display_on, cursor_on, blink_on}), 16'd0);
        check_output("rst_entry",    16'(entry_inc), 16'd1);
        check_output("rst_two_line", 16'(two_line), 16'd0);
        check_output("rst_strobe",   16'(cmd_strobe), 16'd0);
        check_output("rst_overrun",  16'(overrun), 16'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Initialisation sequence.
        do_write(1'b0, 8'h38, 37, "fset");
        do_write(1'b0, 8'h06, 37, "entry");
        do_write(1'b0, 8'h0C, 37, "dctl");
        check_output("init_two_line", 16'(two_line), 16'd1);
        check_output("init_entry",    16'(entry_inc), 16'd1);
        check_output("init_disp",     16'({display_on, cursor_on, blink_on}), 16'b100);
        do_write(1'b0, 8'h01, 1520, "clear");
        check_output("clear_ac", 16'(addr_counter), 16'h00);
        peek(7'h00, 8'h20, "clr_00");
        peek(7'h40, 8'h20, "clr_40");
        peek(7'h7F, 8'h20, "clr_7f");

        // Line-1 to line-2 wrap on increment.
        do_write(1'b0, 8'hA6, 37, "sa26");
        check_output("ac_26", 16'(addr_counter), 16'h26);
        do_write(1'b1, 8'h41, 37, "wr41");
        do_write(1'b1, 8'h42, 37, "wr42");
        check_output("ac_wrap_inc", 16'(addr_counter), 16'h40);
        peek(7'h26, 8'h41, "ram_26");
        peek(7'h27, 8'h42, "ram_27");

        // Wrap on decrement.
        do_write(1'b0, 8'h04, 37, "entry_dec");
        check_output("entry_dec", 16'(entry_inc), 16'd0);
        do_write(1'b0, 8'hC0, 37, "sa40");
        do_write(1'b1, 8'h33, 37, "wr33");
        check_output("ac_wrap_dec", 16'(addr_counter), 16'h27);
        peek(7'h40, 8'h33, "ram_40");
        do_write(1'b0, 8'h06, 37, "entry_inc");

        // Status read while busy, then after busy falls.
        apply_stimulus(1'b0, 8'h92, 1'b0, strobe, len);
        check_output("sa12_strobe", 16'(strobe), 16'd1);
        bus_read(1'b0, v_hi, oe_hi, v_lo, oe_lo);
        check_output("stat_busy_data", 16'(v_hi), 16'h92);
        check_output("stat_oe_high",   16'(oe_hi), 16'd1);
        check_output("stat_oe_low",    16'(oe_lo), 16'd0);
        check_output("stat_hold",      16'(v_lo), 16'h92);
        wait_idle("stat");
        bus_read(1'b0, v_hi, oe_hi, v_lo, oe_lo);
        check_output("stat_idle_data", 16'(v_hi), 16'h12);

        // Write while busy is ignored and sets overrun.
        apply_stimulus(1'b1, 8'h41, 1'b0, strobe, len);
        check_output("ovr_first_strobe", 16'(strobe), 16'd1);
        apply_stimulus(1'b1, 8'h55, 1'b0, strobe, len);
        check_output("ovr_second_strobe", 16'(strobe), 16'd0);
        check_output("ovr_flag", 16'(overrun), 16'd1);
        wait_idle("ovr");
        check_output("ovr_ac", 16'(addr_counter), 16'h13);
        peek(7'h12, 8'h41, "ovr_ram_12");
        peek(7'h13, 8'h20, "ovr_ram_13");

        // DDRAM read advances AC without busy.
        do_write(1'b0, 8'h85, 37, "sa05");
        do_write(1'b1, 8'h48, 37, "wr48");
        do_write(1'b0, 8'h85, 37, "sa05b");
        bus_read(1'b1, v_hi, oe_hi, v_lo, oe_lo);
        check_output("rd_data", 16'(v_hi), 16'h48);
        check_output("rd_oe",   16'(oe_hi), 16'd1);
        check_output("rd_ac",   16'(addr_counter), 16'h06);
        check_output("rd_busy", 16'(busy), 16'd0);
        check_output("ovr_sticky", 16'(overrun), 16'd1);

        // Function set with DL=0 is ignored; single-line wrap.
        do_write(1'b0, 8'h28, 37, "fset_dl0");
        check_output("dl0_two_line", 16'(two_line), 16'd1);
        do_write(1'b0, 8'h30, 37, "fset_1line");
        check_output("one_line", 16'(two_line), 16'd0);
        do_write(1'b0, 8'hCF, 37, "sa4f");
        do_write(1'b1, 8'h11, 37, "wr11");
        check_output("ac_wrap_1line", 16'(addr_counter), 16'h00);
        peek(7'h4F, 8'h11, "ram_4f");
        do_write(1'b0, 8'h0F, 37, "dctl_all");
        check_output("disp_all", 16'({display_on, cursor_on, blink_on}), 16'b111);

        // CGRAM address is a no-op; return home.
        do_write(1'b0, 8'h90, 37, "sa10");
        do_write(1'b0, 8'h40, 37, "cgram");
        check_output("cgram_ac", 16'(addr_counter), 16'h10);
        do_write(1'b0, 8'h02, 37, "home");
        check_output("home_ac", 16'(addr_counter), 16'h00);

        // Asynchronous reset in the middle of a clear sweep.
        do_write(1'b0, 8'hB3, 37, "sa33");
        apply_stimulus(1'b0, 8'h01, 1'b0, strobe, len);
        check_output("clr2_strobe", 16'(strobe), 16'd1);
        repeat (20) @(negedge clk);
        check_output("clr2_busy", 16'(busy), 16'd1);
        #2 reset = 1'b1;
        #1;
        check_output("async_busy",    16'(busy), 16'd0);
        check_output("async_ac",      16'(addr_counter), 16'h00);
        check_output("async_overrun", 16'(overrun), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        do_write(1'b0, 8'h38, 37, "post_rst");

`ifdef LCD_RX_SHIFT_EN
        for (int i = 0; i < 41; i++) apply_stimulus(1'b0, 8'h1C, 1'b1, strobe, len);
        check_output("shift_41", 16'(shift_offset), 16'd1);
        do_write(1'b0, 8'h18, 37, "shl1");
        do_write(1'b0, 8'h18, 37, "shl2");
        check_output("shift_wrap", 16'(shift_offset), 16'd39);
        do_write(1'b0, 8'hA7, 37, "sa27");
        do_write(1'b0, 8'h14, 37, "cur_r");
        check_output("cur_shift_ac", 16'(addr_counter), 16'h40);
        do_write(1'b0, 8'h02, 37, "home2");
        check_output("home_shift", 16'(shift_offset), 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
